dmem_bus_if: RTL and testbench
==============================

Name: dmem_bus_if

Overview:
- Memory-stage data-memory bus interface. It sits directly downstream of the pipelined MIPS datapath's M stage.
- It consumes the M-stage ALU result (address), store data and load/store strobes, and runs one transaction at a time on a variable-latency req/ack bus.
- It returns load data as rd_dm to the datapath.
- It raises stall_m to the hazard unit until the transaction completes, so slow memory freezes the pipeline instead of corrupting it.

Parameters:
- ADDR_W, 32, bus address width; low ADDR_W bits of addr are used.
- DATA_W, 32, data word width.
- TIMEOUT, 255, maximum BUSY cycles without bus_ack before an error completion; range 1..65535; counter is 16 bits.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- re_dm  in  1  M-stage load request (dm2reg in M).
- we_dm  in  1  M-stage store request.
- addr  in  ADDR_W  M-stage alu_out (byte address, word aligned).
- wd  in  DATA_W  M-stage store data (wd_dm).
- rd_dm  out  DATA_W  load data returned to the datapath.
- stall_m  out  1  freeze request to the hazard unit (F/D/E/M hold).
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  transaction address.
- bus_wdata  out  DATA_W  write data.
- bus_ack  in  1  transaction complete; valid only while bus_req = 1.
- bus_rdata  in  DATA_W  read data, sampled when bus_ack = 1.
- bus_err  in  1  error response, qualified by bus_ack.
- err_flag  out  1  sticky error indicator.
- err_addr  out  ADDR_W  address of the first failing transaction.

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - state = IDLE;
  - bus_req, bus_we, stall_m, err_flag = 0;
  - rd_dm, bus_addr, bus_wdata, err_addr = 0;
  - timeout counter = 0.
- Reset mid-transaction drops bus_req immediately and abandons the transaction; no completion is reported.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If re_dm | we_dm: stall_m = 1 combinationally in the same cycle; latch addr, wd, and bus_we = we_dm (store wins if both strobes are set); clear the counter; next state BUSY.
  - Otherwise stall_m = 0.
- BUSY:
  - bus_req = 1 (registered output); bus_addr, bus_wdata and bus_we are held stable; stall_m = 1; counter increments each cycle.
  - bus_ack = 1 and bus_err = 0: a load captures bus_rdata into rd_dm; a store leaves rd_dm unchanged. Next state DONE.
  - bus_ack = 1 and bus_err = 1: a load sets rd_dm = 0. Set err_flag; latch err_addr if err_flag was 0. Next state DONE.
  - No ack and counter reaches TIMEOUT: handle as an error completion, identical to bus_err.
  - bus_ack in the same cycle as the timeout: the ack wins.
- DONE:
  - bus_req = 0; stall_m = 0, so the pipeline advances at the end of this cycle and W captures rd_dm. Next state IDLE.
  - The still-present request strobes are ignored in DONE, so there is no reissue.
- Latency: the request appears in cycle t; bus_req is high from t+1; with ack at t+1 (zero wait state), DONE is at t+2. Minimum stall is 2 cycles; stall cycles = 2 + bus wait cycles.
- Back-to-back accesses: the new M-stage request seen in IDLE at t+3 starts immediately; there are no idle bus cycles beyond one.
- bus_ack outside BUSY is ignored.
- rd_dm holds its value between loads.
- err_flag is cleared only by reset.
- Misaligned addr (addr[1:0] ≠ 0) is passed through unchanged; alignment is the bus slave's concern.

Test Plan:
- Load with 3 wait states: re_dm = 1, addr = 0x0000_0040; ack at BUSY cycle 4 with rdata = 0x1234_5678 -> stall_m high for 5 cycles, then rd_dm = 0x1234_5678 in DONE; bus_req held the whole time with bus_we = 0.
- Zero-wait store: we_dm = 1, addr = 0x80, wd = 0xCAFE_F00D; ack in the first BUSY cycle -> bus_we = 1, bus_wdata = 0xCAFE_F00D; stall_m high for exactly 2 cycles; rd_dm unchanged.
- Back-to-back: load (rdata 0xA5A5_A5A5) then a store to 0x84 -> two separate bus_req pulses; no duplicate request in DONE; the second transaction starts the cycle after DONE.
- Timeout: TIMEOUT = 4, load to 0x100, no ack -> after 4 BUSY cycles rd_dm = 0, err_flag = 1, err_addr = 0x100, pipeline released.
- Bus error: load to 0x200 with bus_ack = bus_err = 1; then a second error at 0x300 -> err_addr remains 0x200 and err_flag stays 1.
- Reset in BUSY: assert rst low mid-wait -> bus_req and stall_m drop asynchronously, all outputs 0; after release a new load runs normally.

Source files
------------

// File: rtl/dmem_bus_if.sv
// Memory-stage data-memory bus interface: runs one M-stage load/store at a time on a
// req/ack bus and holds the pipeline (stall_m) until that transaction has completed.
module dmem_bus_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re_dm,
    input  logic              we_dm,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd_dm,
    output logic              stall_m,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err,
    output logic              err_flag,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter value held during the last BUSY cycle that is still allowed to wait.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state_reg, state_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rd_reg, rd_next;
    logic              err_flag_reg, err_flag_next;
    logic [ADDR_W-1:0] err_addr_reg, err_addr_next;
    logic [15:0]       cnt_reg, cnt_next;

    logic accept;
    logic timeout_hit;
    logic complete;
    logic fail;

    assign accept      = (state_reg == IDLE) && (re_dm || we_dm);
    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign complete    = (state_reg == BUSY) && (bus_ack || timeout_hit);
    // An ack in the same cycle as the timeout wins, so the error bit only counts with ack.
    assign fail        = complete && (bus_ack ? bus_err : 1'b1);

    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rd_next       = rd_reg;
        err_flag_next = err_flag_reg;
        err_addr_next = err_addr_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    req_next   = 1'b1;
                    we_next    = we_dm;
                    addr_next  = addr;
                    wdata_next = wd;
                    cnt_next   = 16'd0;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 16'd1;
                if (complete) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    if (!we_reg) begin
                        rd_next = fail ? '0 : bus_rdata;
                    end
                    if (fail) begin
                        err_flag_next = 1'b1;
                        if (!err_flag_reg) begin
                            err_addr_next = addr_reg;
                        end
                    end
                end
            end
            DONE: begin
                // Strobes are still asserted here while the pipeline advances; ignore them.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rd_reg       <= '0;
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
            cnt_reg      <= 16'd0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rd_reg       <= rd_next;
            err_flag_reg <= err_flag_next;
            err_addr_reg <= err_addr_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Gated by reset so that a pending strobe cannot hold the pipeline while in reset.
    assign stall_m   = rst && (accept || (state_reg == BUSY));
    assign bus_req   = req_reg;
    assign bus_we    = we_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign rd_dm     = rd_reg;
    assign err_flag  = err_flag_reg;
    assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if: loads, stores, back-to-back, bus error, reset in BUSY, timeout.
module tb_dmem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_dm, we_dm;
    logic [31:0] addr, wd;
    logic [31:0] rd_dm;
    logic        stall_m, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;
    logic        err_flag;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;

    int          stalls, req_cycles;
    logic        req_at_start, we_seen;
    logic [31:0] addr_seen, wdata_seen;

    always #5 clk = ~clk;

    dmem_bus_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .re_dm(re_dm), .we_dm(we_dm), .addr(addr), .wd(wd),
        .rd_dm(rd_dm), .stall_m(stall_m), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err), .err_flag(err_flag), .err_addr(err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one M-stage access and holds it while stalled, acking in BUSY cycle waits+1
    // when do_ack is set. Returns in the DONE cycle (stall_m low) at posedge+3.
    task automatic txn(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input int waits, input logic do_ack, input logic err, input logic [31:0] rdata);
        int busy;
        busy         = 0;
        stalls       = 0;
        req_cycles   = 0;
        req_at_start = bus_req;
        we_seen      = 1'b0;
        addr_seen    = 32'h0;
        wdata_seen   = 32'h0;
        re_dm = re; we_dm = we; addr = a; wd = d;
        for (int c = 0; c < 40; c++) begin
            if (bus_req) begin
                busy++;
                req_cycles++;
                if (busy == 1) begin
                    we_seen    = bus_we;
                    addr_seen  = bus_addr;
                    wdata_seen = bus_wdata;
                end
            end
            bus_ack   = do_ack && bus_req && (busy == waits + 1);
            bus_err   = err && bus_ack;
            bus_rdata = rdata;
            #1;
            if (!stall_m) break;
            stalls++;
            @(posedge clk); #2;
        end
        $display("txn re=%0b we=%0b addr=0x%08h stalls=%0d req_cycles=%0d rd_dm=0x%08h err_flag=%0b",
                 re, we, a, stalls, req_cycles, rd_dm, err_flag);
    endtask

    task automatic next_cycle_idle();
        @(posedge clk); #2;
        re_dm = 1'b0; we_dm = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        re_dm = 1'b0; we_dm = 1'b0; addr = 32'h0; wd = 32'h0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); #2;
        chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
        chk("rst_stall", {31'b0, stall_m}, 32'h0);
        chk("rst_rd_dm", rd_dm, 32'h0);
        chk("rst_err_flag", {31'b0, err_flag}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #2;

        // Load with 3 wait states; ack lands on the last BUSY cycle before the timeout.
        txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 1'b1, 1'b0, 32'h1234_5678);
        chk("ld3_stalls", stalls, 32'd5);
        chk("ld3_req_cycles", req_cycles, 32'd4);
        chk("ld3_bus_we", {31'b0, we_seen}, 32'h0);
        chk("ld3_bus_addr", addr_seen, 32'h0000_0040);
        chk("ld3_rd_dm", rd_dm, 32'h1234_5678);
        chk("ld3_done_req", {31'b0, bus_req}, 32'h0);
        chk("ld3_err_flag", {31'b0, err_flag}, 32'h0);
        next_cycle_idle();
        chk("ld3_idle_req", {31'b0, bus_req}, 32'h0);
        chk("hold_rd_dm", rd_dm, 32'h1234_5678);

        // Zero-wait store.
        txn(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("st0_stalls", stalls, 32'd2);
        chk("st0_bus_we", {31'b0, we_seen}, 32'h1);
        chk("st0_bus_wdata", wdata_seen, 32'hCAFE_F00D);
        chk("st0_bus_addr", addr_seen, 32'h0000_0080);
        chk("st0_rd_dm", rd_dm, 32'h1234_5678);
        next_cycle_idle();

        // Back-to-back: load then a store presented the cycle right after DONE.
        txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 1'b1, 1'b0, 32'hA5A5_A5A5);
        chk("b2b_ld_rd_dm", rd_dm, 32'hA5A5_A5A5);
        chk("b2b_ld_req_cycles", req_cycles, 32'd1);
        @(posedge clk); #2;
        txn(1'b0, 1'b1, 32'h0000_0084, 32'h1111_2222, 1, 1'b1, 1'b0, 32'h0);
        chk("b2b_no_dup_req", {31'b0, req_at_start}, 32'h0);
        chk("b2b_st_stalls", stalls, 32'd3);
        chk("b2b_st_req_cycles", req_cycles, 32'd2);
        chk("b2b_st_addr", addr_seen, 32'h0000_0084);
        chk("b2b_st_rd_dm", rd_dm, 32'hA5A5_A5A5);
        next_cycle_idle();

        // Both strobes set: the store wins.
        txn(1'b1, 1'b1, 32'h0000_0088, 32'h3333_4444, 0, 1'b1, 1'b0, 32'h5555_6666);
        chk("both_bus_we", {31'b0, we_seen}, 32'h1);
        chk("both_rd_dm", rd_dm, 32'hA5A5_A5A5);
        next_cycle_idle();

        // Bus errors: first at 0x200 is recorded, second at 0x300 is not.
        txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 1'b1, 1'b1, 32'h7777_7777);
        chk("err1_rd_dm", rd_dm, 32'h0);
        chk("err1_flag", {31'b0, err_flag}, 32'h1);
        chk("err1_addr", err_addr, 32'h0000_0200);
        chk("err1_stalls", stalls, 32'd3);
        next_cycle_idle();
        txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 1'b1, 1'b1, 32'h8888_8888);
        chk("err2_flag", {31'b0, err_flag}, 32'h1);
        chk("err2_addr", err_addr, 32'h0000_0200);
        next_cycle_idle();

        // Reset in BUSY: everything drops at once even with the strobe still held.
        re_dm = 1'b1; addr = 32'h0000_0400;
        @(posedge clk); #2;
        chk("rb_busy_req", {31'b0, bus_req}, 32'h1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rb_req", {31'b0, bus_req}, 32'h0);
        chk("rb_stall", {31'b0, stall_m}, 32'h0);
        chk("rb_bus_addr", bus_addr, 32'h0);
        chk("rb_rd_dm", rd_dm, 32'h0);
        chk("rb_err_flag", {31'b0, err_flag}, 32'h0);
        chk("rb_err_addr", err_addr, 32'h0);
        re_dm = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        chk("rb_after_req", {31'b0, bus_req}, 32'h0);
        txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1, 1'b1, 1'b0, 32'h0BAD_CAFE);
        chk("rb_ld_stalls", stalls, 32'd3);
        chk("rb_ld_rd_dm", rd_dm, 32'h0BAD_CAFE);
        next_cycle_idle();

        // Timeout: no ack for TIMEOUT=4 BUSY cycles.
        txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 1'b0, 1'b0, 32'h9999_9999);
        chk("to_stalls", stalls, 32'd5);
        chk("to_req_cycles", req_cycles, 32'd4);
        chk("to_rd_dm", rd_dm, 32'h0);
        chk("to_err_flag", {31'b0, err_flag}, 32'h1);
        chk("to_err_addr", err_addr, 32'h0000_0100);
        next_cycle_idle();
        chk("to_released", {31'b0, stall_m}, 32'h0);

        // A late ack outside BUSY must be ignored.
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        @(posedge clk); #2;
        bus_ack = 1'b0;
        #1;
        chk("stray_ack_rd_dm", rd_dm, 32'h0);
        chk("stray_ack_req", {31'b0, bus_req}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
